// File: rtl/mips_alu_unit.sv
// MIPS ALU control and execute unit: registered single-cycle ops, iterative
// MULT/MULTU into HI/LO, valid/ready handshakes on both sides.
module mips_alu_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic             r_neg, w_neg_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  logic             w_accept;
  logic             w_retire;
  logic [WIDTH-1:0] w_dec_res;
  logic             w_dec_ill;
  logic             w_dec_mul;
  logic             w_dec_signed;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_dec_neg;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_add;
  logic [PW-1:0]    w_step;
  logic [PW-1:0]    w_prod;

  assign out_valid = (r_state == S_DONE);
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;
  assign hi      = r_hi;
  assign lo      = r_lo;

  // Operation decode; unknown encodings fall to illegal with a zero result
  always_comb begin
    w_dec_res    = '0;
    w_dec_ill    = 1'b0;
    w_dec_mul    = 1'b0;
    w_dec_signed = 1'b0;
    case (ALUOp)
      2'b00: w_dec_res = a + b;
      2'b01: w_dec_res = a - b;
      2'b10: begin
        case (Funct)
          F_ADD:   w_dec_res = a + b;
          F_SUB:   w_dec_res = a - b;
          F_AND:   w_dec_res = a & b;
          F_OR:    w_dec_res = a | b;
          F_XOR:   w_dec_res = a ^ b;
          F_NOR:   w_dec_res = ~(a | b);
          F_SLT:   w_dec_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
          F_SLL:   w_dec_res = b << shamt;
          F_SRL:   w_dec_res = b >> shamt;
          F_SRA:   w_dec_res = WIDTH'($signed(b) >>> shamt);
          F_MULT: begin
            w_dec_mul    = 1'b1;
            w_dec_signed = 1'b1;
          end
          F_MULTU: w_dec_mul = 1'b1;
          F_MFHI:  w_dec_res = r_hi;
          F_MFLO:  w_dec_res = r_lo;
          default: w_dec_ill = 1'b1;
        endcase
      end
      default: w_dec_ill = 1'b1;
    endcase
  end

  // Signed multiply works on magnitudes; the sign is reapplied at the end
  assign w_a_abs   = (w_dec_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_abs   = (w_dec_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_dec_neg = w_dec_signed && (a[WIDTH-1] ^ b[WIDTH-1]);

  // One shift-add step: multiplier sits in the low half and shifts out
  assign w_addend = r_acc[0] ? r_mcand : '0;
  assign w_add    = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, w_addend};
  assign w_step   = {w_add, r_acc[WIDTH-1:1]};
  assign w_prod   = r_neg ? (~w_step + PW'(1)) : w_step;

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_neg_nxt     = r_neg;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_zero_nxt    = r_zero;
    w_illegal_nxt = r_illegal;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    if (r_state == S_MUL) begin
      w_acc_nxt = w_step;
      w_cnt_nxt = r_cnt + SHW'(1);
      if (r_cnt == SHW'(WIDTH - 1)) begin
        w_state_nxt   = S_DONE;
        w_cnt_nxt     = '0;
        w_hi_nxt      = w_prod[PW-1:WIDTH];
        w_lo_nxt      = w_prod[WIDTH-1:0];
        w_result_nxt  = '0;
        w_zero_nxt    = 1'b1;
        w_illegal_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (w_dec_mul) begin
        w_state_nxt = S_MUL;
        w_acc_nxt   = {{WIDTH{1'b0}}, w_b_abs};
        w_mcand_nxt = w_a_abs;
        w_neg_nxt   = w_dec_neg;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt   = S_DONE;
        w_result_nxt  = w_dec_res;
        w_zero_nxt    = (w_dec_res == '0);
        w_illegal_nxt = w_dec_ill;
      end
    end else if (w_retire) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Reset aborts any multiply in flight and clears HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_mcand   <= w_mcand_nxt;
      r_neg     <= w_neg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
      r_zero    <= w_zero_nxt;
      r_illegal <= w_illegal_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Bench for mips_alu_unit: directed scenarios plus random ops against an
// arithmetic reference model of the ALU and HI/LO.
module tb_mips_alu_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [4:0]    shamt;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mips_alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the instruction semantics
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] h,
                                input logic [31:0] l, output logic [31:0] res,
                                output logic ill, output logic mul,
                                output logic [63:0] prod);
    longint sp;
    logic [63:0] ux, uy;
    res = '0; ill = 1'b0; mul = 1'b0; prod = '0;
    if (op == 2'b00) res = x + y;
    else if (op == 2'b01) res = x - y;
    else if (op == 2'b11) ill = 1'b1;
    else begin
      case (fn)
        6'h20: res = x + y;
        6'h22: res = x - y;
        6'h24: res = x & y;
        6'h25: res = x | y;
        6'h26: res = x ^ y;
        6'h27: res = ~(x | y);
        6'h2a: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'h00: res = y << sh;
        6'h02: res = y >> sh;
        6'h03: res = 32'($signed(y) >>> sh);
        6'h18: begin
          mul = 1'b1;
          sp = longint'($signed(x)) * longint'($signed(y));
          prod = 64'(sp);
        end
        6'h19: begin
          mul = 1'b1;
          ux = {32'b0, x};
          uy = {32'b0, y};
          prod = ux * uy;
        end
        6'h10: res = h;
        6'h12: res = l;
        default: ill = 1'b1;
      endcase
    end
  endfunction

  // Issue one op with out_ready held high; check latency, busy time and outputs
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic        ei, em;
    logic [63:0] ep;
    logic [31:0] old_hi;
    int lat, busy, guard;
    model(op, fn, sh, x, y, m_hi, m_lo, er, ei, em, ep);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    ALUOp = op; Funct = fn; shamt = sh; a = x; b = y;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    old_hi = m_hi;
    if (em) {m_hi, m_lo} = ep;
    lat = 1; busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      if (em && lat == W) check({tag, "_hi_early"}, 64'(hi), 64'(old_hi));
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), em ? 64'(W + 1) : 64'(1));
    check({tag, "_busy"}, 64'(busy), em ? 64'(W) : 64'(0));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_zero"}, 64'(zero), 64'(er == 32'd0));
    check({tag, "_illegal"}, 64'(illegal), 64'(ei));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [5:0] legal_fn [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                  6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};
    logic [1:0]  rop;
    logic [5:0]  rfn;
    logic [31:0] ra, rb;
    int rsel, rises;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; Funct = '0; shamt = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_hilo", {32'(hi), 32'(lo)}, 64'(0));
    reset = 1'b0;

    // Back-to-back add then sub
    @(negedge clk);
    in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'h20; a = 32'd5; b = 32'd7;
    @(posedge clk);
    #1 Funct = 6'h22; a = 32'd7; b = 32'd7;
    @(negedge clk);
    check("b2b_valid1", 64'(out_valid), 64'(1));
    check("b2b_result1", 64'(result), 64'd12);
    check("b2b_zero1", 64'(zero), 64'(0));
    check("b2b_illegal1", 64'(illegal), 64'(0));
    check("b2b_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid2", 64'(out_valid), 64'(1));
    check("b2b_result2", 64'(result), 64'(0));
    check("b2b_zero2", 64'(zero), 64'(1));

    do_op("slt_neg", 2'b10, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1);
    check("slt_const", 64'(result), 64'd1);
    do_op("sra", 2'b10, 6'h03, 5'd4, 32'd0, 32'h8000_0000);
    check("sra_const", 64'(result), 64'hF800_0000);
    do_op("srl", 2'b10, 6'h02, 5'd4, 32'd0, 32'h8000_0000);
    check("srl_const", 64'(result), 64'h0800_0000);

    do_op("mult", 2'b10, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd4);
    check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo_const", 64'(lo), 64'hFFFF_FFF4);
    do_op("mflo", 2'b10, 6'h12, 5'd0, 32'd0, 32'd0);
    check("mflo_const", 64'(result), 64'hFFFF_FFF4);
    do_op("multu", 2'b10, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_const", 64'(hi), 64'd1);
    check("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);
    do_op("mfhi", 2'b10, 6'h10, 5'd0, 32'd0, 32'd0);

    // Back-pressure: result held, next op waits until release
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ALUOp = 2'b00; a = 32'd100; b = 32'd23;
    @(posedge clk);
    #1 ALUOp = 2'b10; Funct = 6'h26; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_result", 64'(result), 64'd123);
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'(1));
    check("bp_next_result", 64'(result), 64'hFF00_FF00);
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'(0));

    do_op("ill_aluop", 2'b11, 6'h20, 5'd0, 32'd9, 32'd9);
    do_op("ill_funct", 2'b10, 6'h3f, 5'd0, 32'd9, 32'd9);

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      rsel = int'($urandom_range(0, 9));
      rop = (rsel == 0) ? 2'b00 : (rsel == 1) ? 2'b01 : (rsel == 2) ? 2'b11 : 2'b10;
      rsel = int'($urandom_range(0, 14));
      rfn = (rsel == 14) ? 6'($urandom) : legal_fn[rsel];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op("rand", rop, rfn, 5'($urandom), ra, rb);
    end

    // Reset in the middle of a multiply
    do_op("pre_mult", 2'b10, 6'h19, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    in_valid = 1'b1; ALUOp = 2'b10; Funct = 6'h18; a = 32'd123457; b = 32'hFFFF_FC19;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_hilo", {32'(hi), 32'(lo)}, 64'(0));
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rises = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("abort_no_valid", 64'(rises), 64'(0));
    check("abort_hilo_after", {32'(hi), 32'(lo)}, 64'(0));
    check("abort_in_ready_after", 64'(in_ready), 64'(1));
    do_op("post_abort_mfhi", 2'b10, 6'h10, 5'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
